// File: rtl/alu_pipe.sv
`default_nettype none
// ============================================================================
// Module   : alu_pipe
// Brief    : Two-stage valid/ready pipelined nandgame-style ALU with flags.
// Revision : 1.0
// ============================================================================

package alu_pipe_pkg;
  typedef struct packed {
    logic zx;
    logic nx;
    logic zy;
    logic ny;
    logic f;
    logic no;
  } op_flag_t;
endpackage

module alu_pipe
  import alu_pipe_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  op_flag_t         opc,
  input  logic             ci,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             zr,
  output logic             ng,
  output logic             cy,
  output logic             ov
);

  localparam int MSB = WIDTH - 1;

  // Stage 1 state
  logic             s1_valid;
  logic [WIDTH-1:0] s1_x;
  logic [WIDTH-1:0] s1_y;
  logic             s1_f;
  logic             s1_no;
  logic             s1_ci;

  // Stage 2 state (drives the outputs directly)
  logic             s2_valid;
  logic [WIDTH-1:0] s2_out;
  logic             s2_zr;
  logic             s2_ng;
  logic             s2_cy;
  logic             s2_ov;

  // Handshake
  logic s1_adv;
  logic s2_adv;

  // Combinational datapath
  logic [WIDTH-1:0] x_cond;
  logic [WIDTH-1:0] y_cond;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] func_r;
  logic [WIDTH-1:0] res;
  logic             cy_next;
  logic             ov_next;

  assign s2_adv   = !s2_valid || out_ready;
  assign s1_adv   = !s1_valid || s2_adv;
  assign in_ready = s1_adv;

  always_comb begin
    x_cond = opc.zx ? '0 : x;
    if (opc.nx) x_cond = ~x_cond;
    y_cond = opc.zy ? '0 : y;
    if (opc.ny) y_cond = ~y_cond;
  end

  // Carry is bit WIDTH of a WIDTH+1 bit sum; no sign extension anywhere.
  always_comb begin
    sum     = {1'b0, s1_x} + {1'b0, s1_y} + {{WIDTH{1'b0}}, s1_ci};
    func_r  = s1_f ? sum[MSB:0] : (s1_x & s1_y);
    cy_next = s1_f & sum[WIDTH];
    ov_next = s1_f & (s1_x[MSB] == s1_y[MSB]) & (sum[MSB] != s1_x[MSB]);
    res     = s1_no ? ~func_r : func_r;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_x     <= '0;
      s1_y     <= '0;
      s1_f     <= 1'b0;
      s1_no    <= 1'b0;
      s1_ci    <= 1'b0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_x  <= x_cond;
        s1_y  <= y_cond;
        s1_f  <= opc.f;
        s1_no <= opc.no;
        s1_ci <= ci;
      end
    end
  end

  // Data only reloads on a real beat so idle outputs keep their last value.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_out   <= '0;
      s2_zr    <= 1'b0;
      s2_ng    <= 1'b0;
      s2_cy    <= 1'b0;
      s2_ov    <= 1'b0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_out <= res;
        s2_zr  <= (res == '0);
        s2_ng  <= res[MSB];
        s2_cy  <= cy_next;
        s2_ov  <= ov_next;
      end
    end
  end

  assign out_valid = s2_valid;
  assign out       = s2_out;
  assign zr        = s2_zr;
  assign ng        = s2_ng;
  assign cy        = s2_cy;
  assign ov        = s2_ov;

endmodule

`default_nettype wire

// File: tb/tb_alu_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_pipe
// Brief    : Randomized and directed scoreboard bench for alu_pipe.
// Revision : 1.0
// ============================================================================

module tb_alu_pipe;
  import alu_pipe_pkg::*;

  localparam int W = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst;
  logic           in_valid, in_ready, out_valid, out_ready;
  op_flag_t       opc;
  logic           ci;
  logic [W-1:0]   x, y, out;
  logic           zr, ng, cy, ov;

  logic           v4_in_valid, v4_in_ready, v4_out_valid;
  op_flag_t       v4_opc;
  logic           v4_ci;
  logic [3:0]     v4_x, v4_y, v4_out;
  logic           v4_zr, v4_ng, v4_cy, v4_ov;

  logic           v32_in_valid, v32_in_ready, v32_out_valid;
  op_flag_t       v32_opc;
  logic           v32_ci;
  logic [31:0]    v32_x, v32_y, v32_out;
  logic           v32_zr, v32_ng, v32_cy, v32_ov;

  alu_pipe #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .opc(opc), .ci(ci), .x(x), .y(y), .out_valid(out_valid),
    .out_ready(out_ready), .out(out), .zr(zr), .ng(ng), .cy(cy), .ov(ov)
  );

  alu_pipe #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(v4_in_valid), .in_ready(v4_in_ready),
    .opc(v4_opc), .ci(v4_ci), .x(v4_x), .y(v4_y), .out_valid(v4_out_valid),
    .out_ready(1'b1), .out(v4_out), .zr(v4_zr), .ng(v4_ng), .cy(v4_cy), .ov(v4_ov)
  );

  alu_pipe #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .in_valid(v32_in_valid), .in_ready(v32_in_ready),
    .opc(v32_opc), .ci(v32_ci), .x(v32_x), .y(v32_y), .out_valid(v32_out_valid),
    .out_ready(1'b1), .out(v32_out), .zr(v32_zr), .ng(v32_ng), .cy(v32_cy), .ov(v32_ov)
  );

  typedef struct {
    logic [63:0] out;
    logic        zr, ng, cy, ov;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_err = 0;
  int   cyc = 0;
  bit   chk_lat = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: signed overflow judged by whether the true signed sum fits in w bits.
  function automatic exp_t model(input int w, input op_flag_t o, input logic c,
                                 input logic [63:0] a, input logic [63:0] b);
    exp_t        m;
    logic [63:0] mask, xa, yb, s, r;
    longint      sa, sbv, ssum, smax, smin;
    mask = (64'd1 << w) - 64'd1;
    xa = o.zx ? 64'd0 : (a & mask);
    if (o.nx) xa = ~xa & mask;
    yb = o.zy ? 64'd0 : (b & mask);
    if (o.ny) yb = ~yb & mask;
    m.cy = 1'b0;
    m.ov = 1'b0;
    if (o.f) begin
      s    = xa + yb + {63'd0, c};
      r    = s & mask;
      m.cy = s[w];
      smax = longint'((64'd1 << (w - 1)) - 64'd1);
      smin = -smax - 1;
      sa   = (xa > 64'(smax)) ? longint'(xa) - longint'(64'd1 << w) : longint'(xa);
      sbv  = (yb > 64'(smax)) ? longint'(yb) - longint'(64'd1 << w) : longint'(yb);
      ssum = sa + sbv + longint'({63'd0, c});
      m.ov = (ssum > smax) || (ssum < smin);
    end else begin
      r = xa & yb;
    end
    if (o.no) r = ~r & mask;
    m.out = r;
    m.zr  = (r == 64'd0);
    m.ng  = r[w-1];
    m.cy  = m.cy;
    m.cyc = 0;
    return m;
  endfunction

  // Called at a negedge with inputs applied; observes, scores, then advances one cycle.
  task automatic cycle(output bit acc);
    exp_t e;
    #1;
    acc = 1'b0;
    if (sb.size() == 0) begin
      check("idle_out_valid", 64'(out_valid), 64'd0);
    end else if (out_valid) begin
      e = sb[0];
      check("out", 64'(out), e.out);
      check("zr", 64'(zr), 64'(e.zr));
      check("ng", 64'(ng), 64'(e.ng));
      check("cy", 64'(cy), 64'(e.cy));
      check("ov", 64'(ov), 64'(e.ov));
      if (out_ready) begin
        if (chk_lat) check("latency", 64'(cyc - e.cyc), 64'd2);
        void'(sb.pop_front());
      end
    end
    if (in_valid && in_ready) begin
      e     = model(W, opc, ci, 64'(x), 64'(y));
      e.cyc = cyc;
      sb.push_back(e);
      acc = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic send(input op_flag_t o, input logic c, input logic [W-1:0] a, input logic [W-1:0] b);
    bit acc;
    int n;
    opc = o; ci = c; x = a; y = b; in_valid = 1'b1;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 50) begin
      cycle(acc);
      n++;
    end
    check("send_accepted", 64'(acc), 64'd1);
  endtask

  task automatic drain();
    bit acc;
    int n;
    in_valid = 1'b0;
    n = 0;
    while (sb.size() > 0 && n < 60) begin
      cycle(acc);
      n++;
    end
    check("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  function automatic logic [W-1:0] rand_val();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return '1;
      2: return 16'h7FFF;
      3: return 16'h8000;
      default: return W'($urandom);
    endcase
  endfunction

  logic [31:0] t32_x [3] = '{32'd5, 32'hFFFF_FFFF, 32'h7FFF_FFFF};
  logic [31:0] t32_y [3] = '{32'd3, 32'h0000_0001, 32'h0000_0001};
  logic [31:0] t32_o [3] = '{32'd8, 32'h0000_0000, 32'h8000_0000};
  logic [3:0]  t32_f [3] = '{4'b0000, 4'b1010, 4'b0101};  // {zr, ng, cy, ov}

  initial begin
    bit acc;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    opc = '0; ci = 1'b0; x = '0; y = '0;
    v4_in_valid = 1'b0; v4_opc = '0; v4_ci = 1'b0; v4_x = '0; v4_y = '0;
    v32_in_valid = 1'b0; v32_opc = '0; v32_ci = 1'b0; v32_x = '0; v32_y = '0;

    repeat (2) @(negedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out", 64'(out), 64'd0);
    check("rst_flags", 64'({zr, ng, cy, ov}), 64'd0);
    rst = 1'b0;
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);

    // Directed arithmetic with streaming latency checks
    chk_lat = 1'b1;
    send(op_flag_t'(6'b000010), 1'b0, 16'd5, 16'd3);
    send(op_flag_t'(6'b000010), 1'b0, 16'hFFFF, 16'h0001);
    send(op_flag_t'(6'b000010), 1'b0, 16'h7FFF, 16'h0001);
    send(op_flag_t'(6'b010011), 1'b0, 16'd7, 16'd3);
    send(op_flag_t'(6'b000001), 1'b0, 16'h00F0, 16'h0FF0);
    drain();

    // Back-pressure: A, B fill both stages, C must wait
    chk_lat = 1'b0;
    out_ready = 1'b0;
    send(op_flag_t'(6'b000010), 1'b0, 16'h1111, 16'h0001);
    send(op_flag_t'(6'b000010), 1'b1, 16'h2222, 16'h0002);
    opc = op_flag_t'(6'b000001); ci = 1'b0; x = 16'h3333; y = 16'h0F0F; in_valid = 1'b1;
    #1;
    check("bp_in_ready_full", 64'(in_ready), 64'd0);
    repeat (3) begin
      cycle(acc);
      check("bp_hold_no_accept", 64'(acc), 64'd0);
    end
    out_ready = 1'b1;
    send(op_flag_t'(6'b000001), 1'b0, 16'h3333, 16'h0F0F);
    in_valid = 1'b0;
    repeat (2) begin
      #1;
      check("bp_consecutive", 64'(out_valid), 64'd1);
      cycle(acc);
    end
    drain();

    // Eight back-to-back beats
    chk_lat = 1'b1;
    for (int i = 0; i < 8; i++)
      send(op_flag_t'(6'($urandom_range(0, 63))), 1'($urandom), rand_val(), rand_val());
    drain();

    // Mid-operation reset with two beats in flight
    chk_lat = 1'b0;
    out_ready = 1'b0;
    send(op_flag_t'(6'b000010), 1'b0, 16'hFFFF, 16'hFFFF);
    send(op_flag_t'(6'b000010), 1'b0, 16'h8000, 16'h8000);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_out", 64'(out), 64'd0);
    check("midrst_flags", 64'({zr, ng, cy, ov}), 64'd0);
    sb.delete();
    rst = 1'b0;
    out_ready = 1'b1;
    repeat (4) cycle(acc);

    // Randomized traffic with random back-pressure
    for (int i = 0; i < 400; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      opc = op_flag_t'(6'($urandom_range(0, 63)));
      ci  = 1'($urandom);
      x   = rand_val();
      y   = rand_val();
      cycle(acc);
    end
    out_ready = 1'b1;
    drain();

    // Width sweep: 32-bit add/wrap/overflow
    for (int i = 0; i < 3; i++) begin
      v32_opc = op_flag_t'(6'b000010); v32_ci = 1'b0;
      v32_x = t32_x[i]; v32_y = t32_y[i]; v32_in_valid = 1'b1;
      #1;
      check("w32_in_ready", 64'(v32_in_ready), 64'd1);
      @(negedge clk);
      v32_in_valid = 1'b0;
      #1;
      check("w32_early_valid", 64'(v32_out_valid), 64'd0);
      @(negedge clk);
      #1;
      check("w32_out_valid", 64'(v32_out_valid), 64'd1);
      check("w32_out", 64'(v32_out), 64'(t32_o[i]));
      check("w32_flags", 64'({v32_zr, v32_ng, v32_cy, v32_ov}), 64'(t32_f[i]));
      @(negedge clk);
    end

    // Width sweep: 4-bit carry-in wrap
    v4_opc = op_flag_t'(6'b000010); v4_ci = 1'b1; v4_x = 4'hF; v4_y = 4'h0; v4_in_valid = 1'b1;
    @(negedge clk);
    v4_in_valid = 1'b0;
    @(negedge clk);
    #1;
    check("w4_out_valid", 64'(v4_out_valid), 64'd1);
    check("w4_out", 64'(v4_out), 64'd0);
    check("w4_flags", 64'({v4_zr, v4_ng, v4_cy, v4_ov}), 64'b1010);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

endmodule

`default_nettype wire
